// File: rtl/heat_pkg.sv
// Shared constants, host command encodings and FSM state type for the heat sweep controller.
package heat_pkg;

    localparam int GRID_N = 6;
    localparam int CELLS  = GRID_N * GRID_N;
    localparam int DATA_W = 4;

    localparam logic [1:0] CMD_RUN = 2'b00;
    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [1:0] CMD_RD  = 2'b10;
    localparam logic [1:0] CMD_CFG = 2'b11;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        RD_C = 4'd1,
        RD_N = 4'd2,
        RD_S = 4'd3,
        RD_W = 4'd4,
        RD_E = 4'd5,
        WAIT = 4'd6,
        WB   = 4'd7,
        SWAP = 4'd8
    } state_t;

endpackage

// File: rtl/heat_cell_update.sv
// Combinational explicit diffusion step for one cell: new = sat(c + ((N+S+W+E-4c)*alpha) >>> 4).
module heat_cell_update
    import heat_pkg::*;
(
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] n,
    input  logic [DATA_W-1:0] s,
    input  logic [DATA_W-1:0] w,
    input  logic [DATA_W-1:0] e,
    input  logic [DATA_W-1:0] alpha,
    output logic [DATA_W-1:0] upd
);

    logic        [5:0]  sum4_s;
    logic signed [6:0]  lap_s;
    logic signed [11:0] prod_s;
    logic signed [11:0] shr_s;
    logic signed [11:0] sum_s;

    // Laplacian, scaled by alpha/16 with floor rounding, then clamped to the 4-bit range.
    always_comb begin
        sum4_s = {2'b00, n} + {2'b00, s} + {2'b00, w} + {2'b00, e};
        lap_s  = $signed({1'b0, sum4_s}) - $signed({1'b0, c, 2'b00});
        prod_s = 12'(lap_s) * 12'($signed({1'b0, alpha}));
        shr_s  = prod_s >>> 4;
        sum_s  = $signed({8'd0, c}) + shr_s;
        if (sum_s < 12'sd0) begin
            upd = 4'd0;
        end else if (sum_s > 12'sd15) begin
            upd = 4'd15;
        end else begin
            upd = sum_s[3:0];
        end
    end

endmodule

// File: rtl/heat_sweep_ctrl.sv
// Jacobi heat-diffusion sweeper over a GRID_N x GRID_N grid held in an external dual-bank RAM.
// Build option HEAT_ITER_LIMIT_EN: a nonzero configured limit stops run mode at iter_count == limit.
module heat_sweep_ctrl #(
    parameter int GRID_N = heat_pkg::GRID_N,
    parameter int ITER_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [1:0]        cmd,
    input  logic [5:0]        cmd_addr,
    input  logic [7:0]        cmd_data,
    output logic [6:0]        mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_wdata,
    input  logic [3:0]        mem_rdata,
    output logic [3:0]        rd_data,
    output logic [3:0]        alpha,
    output logic [ITER_W-1:0] iter_count,
    output logic              busy,
    output logic              sweep_done
);
    import heat_pkg::*;

    localparam logic [5:0] EDGE      = 6'(GRID_N);
    localparam logic [5:0] LAST_CELL = 6'(GRID_N * GRID_N - 1);
    localparam logic [5:0] LAST_ROW  = 6'(GRID_N * GRID_N - GRID_N);

    state_t            state_r, state_s;
    logic              bank_r, bank_s;
    logic [5:0]        cell_r, cell_s;
    logic [3:0]        alpha_r, alpha_s;
    logic [3:0]        limit_r, limit_s;
    logic [ITER_W-1:0] iter_r, iter_s;
    logic [3:0]        c_r, c_s, n_r, n_s, s_r, s_s, w_r, w_s;
    logic [2:0]        rd_v_r, rd_v_s;
    logic [3:0]        rd_buf_r, rd_buf_s;
    logic [3:0]        rd_data_r, rd_data_s;
    logic [6:0]        mem_addr_r, mem_addr_s;
    logic              mem_we_r, mem_we_s;
    logic [3:0]        mem_wdata_r, mem_wdata_s;
    logic              busy_r;
    logic              sweep_done_r, sweep_done_s;

    logic [5:0]        col_s;
    logic              has_n_s, has_s_s, has_w_s, has_e_s;
    logic [5:0]        n_addr_s, s_addr_s, w_addr_s, e_addr_s;
    logic [3:0]        e_s, upd_s;
    logic              run_ok_s;

`ifdef HEAT_ITER_LIMIT_EN
    assign run_ok_s = (limit_r == 4'd0) || (iter_r != ITER_W'(limit_r));
`else
    logic unused_limit_s;
    assign run_ok_s       = 1'b1;
    assign unused_limit_s = ^limit_r;
`endif

    // Neighbour addressing; a missing neighbour re-reads the centre and is later forced to 0.
    always_comb begin
        col_s    = cell_r % EDGE;
        has_n_s  = (cell_r >= EDGE);
        has_s_s  = (cell_r < LAST_ROW);
        has_w_s  = (col_s != 6'd0);
        has_e_s  = (col_s != (EDGE - 6'd1));
        n_addr_s = has_n_s ? (cell_r - EDGE)  : cell_r;
        s_addr_s = has_s_s ? (cell_r + EDGE)  : cell_r;
        w_addr_s = has_w_s ? (cell_r - 6'd1)  : cell_r;
        e_addr_s = has_e_s ? (cell_r + 6'd1)  : cell_r;
        e_s      = has_e_s ? mem_rdata : 4'd0;
    end

    heat_cell_update u_update (
        .c     (c_r),
        .n     (n_r),
        .s     (s_r),
        .w     (w_r),
        .e     (e_s),
        .alpha (alpha_r),
        .upd   (upd_s)
    );

    // Next-state and next-output logic; RAM data arrives two states after its address is issued.
    always_comb begin
        state_s      = state_r;
        bank_s       = bank_r;
        cell_s       = cell_r;
        alpha_s      = alpha_r;
        limit_s      = limit_r;
        iter_s       = iter_r;
        c_s          = c_r;
        n_s          = n_r;
        s_s          = s_r;
        w_s          = w_r;
        mem_addr_s   = mem_addr_r;
        mem_we_s     = 1'b0;
        mem_wdata_s  = mem_wdata_r;
        sweep_done_s = 1'b0;
        rd_v_s       = {rd_v_r[1:0], 1'b0};
        rd_buf_s     = rd_v_r[1] ? mem_rdata : rd_buf_r;
        rd_data_s    = rd_v_r[2] ? rd_buf_r  : rd_data_r;

        case (state_r)
            IDLE: begin
                case (cmd)
                    CMD_RUN: begin
                        if (run_ok_s) begin
                            state_s    = RD_C;
                            mem_addr_s = {bank_r, cell_r};
                        end else begin
                            state_s    = IDLE;
                        end
                    end
                    CMD_WR: begin
                        mem_we_s    = 1'b1;
                        mem_addr_s  = {bank_r, cmd_addr};
                        mem_wdata_s = cmd_data[3:0];
                    end
                    CMD_RD: begin
                        mem_addr_s = {bank_r, cmd_addr};
                        rd_v_s[0]  = 1'b1;
                    end
                    CMD_CFG: begin
                        alpha_s = cmd_data[3:0];
                        limit_s = cmd_data[7:4];
                        iter_s  = '0;
                        cell_s  = 6'd0;
                    end
                    default: state_s = IDLE;
                endcase
            end
            RD_C: begin
                state_s    = RD_N;
                mem_addr_s = {bank_r, n_addr_s};
            end
            RD_N: begin
                state_s    = RD_S;
                mem_addr_s = {bank_r, s_addr_s};
                c_s        = mem_rdata;
            end
            RD_S: begin
                state_s    = RD_W;
                mem_addr_s = {bank_r, w_addr_s};
                n_s        = has_n_s ? mem_rdata : 4'd0;
            end
            RD_W: begin
                state_s    = RD_E;
                mem_addr_s = {bank_r, e_addr_s};
                s_s        = has_s_s ? mem_rdata : 4'd0;
            end
            RD_E: begin
                state_s = WAIT;
                w_s     = has_w_s ? mem_rdata : 4'd0;
            end
            WAIT: begin
                state_s     = WB;
                mem_we_s    = 1'b1;
                mem_addr_s  = {~bank_r, cell_r};
                mem_wdata_s = upd_s;
            end
            WB: begin
                if (cell_r == LAST_CELL) begin
                    state_s = SWAP;
                end else begin
                    cell_s = cell_r + 6'd1;
                    if (cmd == CMD_RUN) begin
                        state_s    = RD_C;
                        mem_addr_s = {bank_r, cell_r + 6'd1};
                    end else begin
                        state_s    = IDLE;
                    end
                end
            end
            SWAP: begin
                state_s      = IDLE;
                bank_s       = ~bank_r;
                iter_s       = iter_r + {{(ITER_W-1){1'b0}}, 1'b1};
                sweep_done_s = 1'b1;
                cell_s       = 6'd0;
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM state register; ena low holds the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else if (ena) begin
            state_r <= state_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Datapath and output registers; ena low freezes everything and suppresses RAM writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_r       <= 1'b0;
            cell_r       <= 6'd0;
            alpha_r      <= 4'd0;
            limit_r      <= 4'd0;
            iter_r       <= '0;
            c_r          <= 4'd0;
            n_r          <= 4'd0;
            s_r          <= 4'd0;
            w_r          <= 4'd0;
            rd_v_r       <= 3'd0;
            rd_buf_r     <= 4'd0;
            rd_data_r    <= 4'd0;
            mem_addr_r   <= 7'd0;
            mem_we_r     <= 1'b0;
            mem_wdata_r  <= 4'd0;
            busy_r       <= 1'b0;
            sweep_done_r <= 1'b0;
        end else if (ena) begin
            bank_r       <= bank_s;
            cell_r       <= cell_s;
            alpha_r      <= alpha_s;
            limit_r      <= limit_s;
            iter_r       <= iter_s;
            c_r          <= c_s;
            n_r          <= n_s;
            s_r          <= s_s;
            w_r          <= w_s;
            rd_v_r       <= rd_v_s;
            rd_buf_r     <= rd_buf_s;
            rd_data_r    <= rd_data_s;
            mem_addr_r   <= mem_addr_s;
            mem_we_r     <= mem_we_s;
            mem_wdata_r  <= mem_wdata_s;
            busy_r       <= (state_s != IDLE);
            sweep_done_r <= sweep_done_s;
        end else begin
            mem_we_r     <= 1'b0;
        end
    end

    assign mem_addr   = mem_addr_r;
    assign mem_we     = mem_we_r;
    assign mem_wdata  = mem_wdata_r;
    assign rd_data    = rd_data_r;
    assign alpha      = alpha_r;
    assign iter_count = iter_r;
    assign busy       = busy_r;
    assign sweep_done = sweep_done_r;

endmodule

// File: tb/tb_heat_sweep_ctrl.sv
// Self-checking bench for heat_sweep_ctrl: behavioural RAM, grid-level diffusion model, randomized grids.
// Honours HEAT_ITER_LIMIT_EN to select the expected run-limit behaviour.
module tb_heat_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [1:0] cmd = 2'b10;
    logic [5:0] cmd_addr = 6'd0;
    logic [7:0] cmd_data = 8'd0;
    logic [6:0] mem_addr;
    logic       mem_we;
    logic [3:0] mem_wdata;
    logic [3:0] mem_rdata;
    logic [3:0] rd_data;
    logic [3:0] alpha;
    logic [7:0] iter_count;
    logic       busy;
    logic       sweep_done;

    int checks = 0;
    int errors = 0;
    int grid [36];
    int got_g [36];
    logic [3:0] ram [0:127] = '{default: 4'h0};

`ifdef HEAT_ITER_LIMIT_EN
    localparam int EXP_PULSES = 3;
    localparam logic EXP_BUSY = 1'b0;
`else
    localparam int EXP_PULSES = 4;
    localparam logic EXP_BUSY = 1'b1;
`endif

    heat_sweep_ctrl #(.GRID_N(6), .ITER_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cmd        (cmd),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rd_data    (rd_data),
        .alpha      (alpha),
        .iter_count (iter_count),
        .busy       (busy),
        .sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: data for an address is visible the cycle after it is presented.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    function automatic int cell_at(int r, int c);
        if (r < 0 || r > 5 || c < 0 || c > 5) return 0;
        return grid[r*6 + c];
    endfunction

    // One Jacobi step of the whole grid, computed from the old grid only.
    task automatic model_sweep(input int a);
        int nxt [36];
        int ctr, lap, t, d, v;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                ctr = grid[r*6 + c];
                lap = cell_at(r-1, c) + cell_at(r+1, c) + cell_at(r, c-1) + cell_at(r, c+1) - 4*ctr;
                t   = lap * a;
                d   = (t >= 0) ? t / 16 : -((-t + 15) / 16);
                v   = ctr + d;
                if (v < 0) v = 0;
                if (v > 15) v = 15;
                nxt[r*6 + c] = v;
            end
        end
        for (int i = 0; i < 36; i++) grid[i] = nxt[i];
    endtask

    task automatic host_write(input int a, input int d);
        cmd = 2'b01; cmd_addr = 6'(a); cmd_data = {4'h0, 4'(d)};
        @(posedge clk); #1;
        cmd = 2'b10; cmd_addr = 6'd0;
    endtask

    task automatic host_cfg(input int a, input int lim);
        cmd = 2'b11; cmd_data = {4'(lim), 4'(a)};
        @(posedge clk); #1;
        cmd = 2'b10; cmd_addr = 6'd0;
    endtask

    task automatic host_read(input int a, output int v);
        cmd = 2'b10; cmd_addr = 6'(a);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 v = int'(rd_data);
    endtask

    task automatic read_all();
        int v;
        for (int i = 0; i < 36; i++) begin
            host_read(i, v);
            got_g[i] = v;
        end
    endtask

    task automatic load_grid();
        for (int i = 0; i < 36; i++) host_write(i, grid[i]);
    endtask

    // Holds run until sweep_done; n counts edges after the sampling edge (bounded).
    task automatic run_sweep(output int n);
        cmd = 2'b00;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!sweep_done && n < 400);
        cmd = 2'b10; cmd_addr = 6'd0;
    endtask

    task automatic test_reset();
        int v;
        rst_n = 1'b0; ena = 1'b1; cmd = 2'b10; cmd_addr = 6'd0; cmd_data = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if ({mem_addr, mem_we, mem_wdata, rd_data, alpha, iter_count, busy, sweep_done} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {mem_addr, mem_we, mem_wdata, rd_data, alpha, iter_count, busy, sweep_done});
        end
        host_read(7, v);
        checks++;
        if (v !== 0 || busy !== 1'b0 || alpha !== 4'd0 || iter_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_read7: rd=%0d busy=%0b alpha=%0d iter=%0d expected all 0", v, busy, alpha, iter_count);
        end
    endtask

    task automatic test_read_latency();
        host_write(12, 9);
        cmd = 2'b10; cmd_addr = 6'd12;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rd_data !== 4'd0) begin
            errors++;
            $display("FAIL read_early: rd_data %0d expected 0 two cycles after sampling", rd_data);
        end
        @(posedge clk); #1;
        checks++;
        if (rd_data !== 4'd9) begin
            errors++;
            $display("FAIL read_lat3: rd_data %0d expected 9", rd_data);
        end
    endtask

    task automatic test_uniform();
        int n;
        host_cfg(2, 0);
        for (int i = 0; i < 36; i++) grid[i] = 5;
        load_grid();
        run_sweep(n);
        checks++;
        if (n !== 253) begin
            errors++;
            $display("FAIL uniform_timing: sweep_done after %0d cycles expected 253", n);
        end
        model_sweep(2);
        read_all();
        for (int i = 0; i < 36; i++) begin
            checks++;
            if (got_g[i] !== grid[i]) begin
                errors++;
                $display("FAIL uniform_cell%0d: got %0d expected %0d", i, got_g[i], grid[i]);
            end
        end
        checks++;
        if (got_g[0] !== 3 || got_g[1] !== 4 || got_g[7] !== 5 || iter_count !== 8'd1 || alpha !== 4'd2) begin
            errors++;
            $display("FAIL uniform_fixed: c0=%0d c1=%0d c7=%0d iter=%0d alpha=%0d expected 3 4 5 1 2", got_g[0], got_g[1], got_g[7], iter_count, alpha);
        end
    endtask

    task automatic test_jacobi();
        int n;
        host_cfg(4, 0);
        for (int i = 0; i < 36; i++) grid[i] = (i == 0) ? 15 : 0;
        load_grid();
        run_sweep(n);
        model_sweep(4);
        read_all();
        for (int i = 0; i < 36; i++) begin
            checks++;
            if (got_g[i] !== grid[i]) begin
                errors++;
                $display("FAIL jacobi_cell%0d: got %0d expected %0d", i, got_g[i], grid[i]);
            end
        end
        checks++;
        if (got_g[0] !== 0 || got_g[1] !== 3 || got_g[6] !== 3 || got_g[2] !== 0) begin
            errors++;
            $display("FAIL jacobi_fixed: c0=%0d c1=%0d c6=%0d c2=%0d expected 0 3 3 0", got_g[0], got_g[1], got_g[6], got_g[2]);
        end
    endtask

    task automatic test_random();
        int a, sweeps, n;
        for (int round = 0; round < 3; round++) begin
            a = $urandom_range(0, 15);
            sweeps = $urandom_range(1, 2);
            host_cfg(a, 0);
            for (int i = 0; i < 36; i++) grid[i] = $urandom_range(0, 15);
            load_grid();
            for (int k = 0; k < sweeps; k++) begin
                run_sweep(n);
                model_sweep(a);
                checks++;
                if (n !== 253) begin
                    errors++;
                    $display("FAIL random_timing: %0d cycles expected 253", n);
                end
            end
            checks++;
            if (iter_count !== 8'(sweeps)) begin
                errors++;
                $display("FAIL random_iter: iter_count %0d expected %0d", iter_count, sweeps);
            end
            read_all();
            for (int i = 0; i < 36; i++) begin
                checks++;
                if (got_g[i] !== grid[i]) begin
                    errors++;
                    $display("FAIL random_cell%0d: alpha %0d got %0d expected %0d", i, a, got_g[i], grid[i]);
                end
            end
        end
    endtask

    task automatic test_pause();
        int a, nwr, last_cell, last_t, n;
        a = $urandom_range(1, 15);
        host_cfg(a, 0);
        for (int i = 0; i < 36; i++) grid[i] = $urandom_range(0, 15);
        load_grid();
        nwr = 0; last_cell = -1; last_t = -1;
        cmd = 2'b00;
        @(posedge clk);
        for (int i = 1; i <= 24; i++) begin
            @(posedge clk); #1;
            if (i == 10) begin
                cmd = 2'b10; cmd_addr = 6'd0;
            end
            if (mem_we) begin
                nwr++; last_cell = int'(mem_addr[5:0]); last_t = i;
            end
        end
        checks++;
        if (nwr !== 2 || last_cell !== 1 || last_t !== 13 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pause_stop: writes=%0d last_cell=%0d at=%0d busy=%0b expected 2 1 13 0", nwr, last_cell, last_t, busy);
        end
        run_sweep(n);
        checks++;
        if (n !== 239) begin
            errors++;
            $display("FAIL pause_resume: %0d cycles expected 239", n);
        end
        model_sweep(a);
        read_all();
        for (int i = 0; i < 36; i++) begin
            checks++;
            if (got_g[i] !== grid[i]) begin
                errors++;
                $display("FAIL pause_cell%0d: got %0d expected %0d", i, got_g[i], grid[i]);
            end
        end
    endtask

    task automatic test_ena();
        int v, we_seen;
        we_seen = 0;
        ena = 1'b0; cmd = 2'b01; cmd_addr = 6'd5; cmd_data = 8'h0e;
        repeat (3) begin
            @(posedge clk); #1;
            if (mem_we) we_seen++;
        end
        cmd = 2'b10; cmd_addr = 6'd0; ena = 1'b1;
        checks++;
        if (we_seen !== 0) begin
            errors++;
            $display("FAIL ena_we: mem_we high %0d cycles expected 0", we_seen);
        end
        host_read(5, v);
        checks++;
        if (v !== grid[5]) begin
            errors++;
            $display("FAIL ena_cell5: got %0d expected %0d", v, grid[5]);
        end
    endtask

    task automatic test_reset_mid();
        int v;
        cmd = 2'b00;
        @(posedge clk);
        repeat (50) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_addr, mem_we, mem_wdata, rd_data, alpha, iter_count, busy, sweep_done} !== 29'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h expected 0", {mem_addr, mem_we, mem_wdata, rd_data, alpha, iter_count, busy, sweep_done});
        end
        cmd = 2'b10; cmd_addr = 6'd0;
        @(posedge clk); #1 rst_n = 1'b1;
        cmd = 2'b01; cmd_addr = 6'd3; cmd_data = 8'h09;
        @(posedge clk); #1;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 7'd3) begin
            errors++;
            $display("FAIL midreset_bank: we=%0b addr=%0d expected 1 3", mem_we, mem_addr);
        end
        cmd = 2'b10; cmd_addr = 6'd0;
        host_read(3, v);
        checks++;
        if (v !== 9) begin
            errors++;
            $display("FAIL midreset_read: got %0d expected 9", v);
        end
    endtask

    task automatic test_limit();
        int pulses;
        pulses = 0;
        host_cfg(1, 3);
        cmd = 2'b00;
        for (int i = 0; i < 1100; i++) begin
            @(posedge clk); #1;
            if (sweep_done) pulses++;
        end
        checks++;
        if (pulses !== EXP_PULSES || iter_count !== 8'(EXP_PULSES) || busy !== EXP_BUSY) begin
            errors++;
            $display("FAIL limit: pulses=%0d iter=%0d busy=%0b expected %0d %0d %0b", pulses, iter_count, busy, EXP_PULSES, EXP_PULSES, EXP_BUSY);
        end
        cmd = 2'b10; cmd_addr = 6'd0;
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_uniform();
        test_jacobi();
        test_random();
        test_pause();
        test_ena();
        test_reset_mid();
        test_limit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/heat_sweep_ctrl.md
HEAT_SWEEP_CTRL -- requirements
Module: heat_sweep_ctrl

Interface
REQ-001 Parameter GRID_N, 6, grid edge length in cells (36 cells, row-major, cell = row*6+col).
REQ-002 Parameter ITER_W, 8, width of the iteration counter.
REQ-003 clk  input  1  single clock; all state on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 ena  input  1  block enable; low freezes all state and forces mem_we=0.
REQ-006 cmd  input  2  host command: 00 run, 01 write cell, 10 read cell, 11 config.
REQ-007 cmd_addr  input  6  host cell index, 0..35.
REQ-008 cmd_data  input  8  [3:0] write data or alpha; [7:4] iteration limit.
REQ-009 mem_addr  output  7  {bank, cell} address to the dual-bank 4-bit grid RAM.
REQ-010 mem_we  output  1  RAM write strobe.
REQ-011 mem_wdata  output  4  RAM write data.
REQ-012 mem_rdata  input  4  RAM read data, valid the cycle after mem_addr is presented.
REQ-013 rd_data  output  4  last host-read cell value.
REQ-014 alpha  output  4  current diffusion coefficient.
REQ-015 iter_count  output  ITER_W  completed sweeps; wraps at 2^ITER_W.
REQ-016 busy  output  1  high while not in IDLE.
REQ-017 sweep_done  output  1  one-cycle pulse when a sweep completes.

Function
REQ-018 All outputs SHALL be registered; commands SHALL be level-sensitive and sampled only in IDLE with ena=1.
REQ-019 FSM states SHALL be IDLE, RD_C, RD_N, RD_S, RD_W, RD_E, WAIT, WB, SWAP; per cell RD_C..WB takes exactly 7 cycles, and a full sweep takes 36*7+1 = 253 cycles.
REQ-020 RD_* states SHALL read {bank, cell} for centre/N/S/W/E; an out-of-grid neighbour SHALL re-address the centre and its value SHALL be replaced by 0 (cold boundary).
REQ-021 WB SHALL write the updated value to {~bank, cell} (Jacobi); SWAP SHALL toggle bank, increment iter_count, pulse sweep_done and reset the cell index to 0.
REQ-022 Update: sum4 = unsigned 6-bit N+S+W+E; lap = sum4 - 4*c (signed 7-bit); d = (lap*alpha) >>> 4 (arithmetic, floor); new = c + d saturated to 0..15.
REQ-023 Host write (01): mem_we=1 to {bank, cmd_addr} with cmd_data[3:0] one cycle after sampling.
REQ-024 Host read (10): rd_data SHALL update from {bank, cmd_addr} exactly 3 cycles after sampling and hold until the next read.
REQ-025 Config (11): alpha <= cmd_data[3:0], iteration limit <= cmd_data[7:4], iter_count <= 0, cell index <= 0.
REQ-026 cmd != 00 during a sweep SHALL pause the sweep after the current cell's WB; the cell index and bank SHALL be retained, and the sweep SHALL resume at the next cell on cmd = 00.
REQ-027 The last cell's WB SHALL be followed directly by SWAP, even if a pause is requested.

Reset
REQ-028 Reset SHALL force IDLE, bank=0, cell index=0, alpha=0, limit=0, iter_count=0, rd_data=0, mem_*=0, busy=0, sweep_done=0; reset mid-sweep abandons the sweep, and RAM contents are not touched.

Configuration
REQ-029 With HEAT_ITER_LIMIT_EN defined, a nonzero limit SHALL stop run after iter_count == limit, ignoring cmd = 00 until the next config; limit = 0 means unlimited.
REQ-030 Without HEAT_ITER_LIMIT_EN, cmd_data[7:4] SHALL be ignored and run SHALL be unbounded.

Structure
REQ-031 Package heat_pkg SHALL hold GRID_N, CELLS=36, the data width of 4, the CMD_* encodings and the FSM state enum.
REQ-032 The update arithmetic SHALL be the combinational sub-module heat_cell_update (c, n, s, w, e, alpha -> new).

Verification
REQ-033 Reset, then read cell 7 -> rd_data=0, busy=0, alpha=0, iter_count=0.
REQ-034 Config alpha=2; write 5 to all 36 cells; run 1 sweep -> corner cells 3, edge non-corner cells 4, interior cells 5, sweep_done pulses at cycle 253.
REQ-035 Config alpha=4; cell 0=15, all others 0; run 1 sweep -> cell 0=0, cells 1 and 6=3, others 0 (confirms Jacobi ordering).
REQ-036 Pause: cmd=10 at cycle 10 of a sweep -> mem_we seen at the cell-1 WB, then IDLE; resume completes the sweep with the same result as an unpaused sweep.
REQ-037 Assert rst_n low mid-sweep -> all outputs 0 within the same cycle, bank=0 afterwards.
REQ-038 HEAT_ITER_LIMIT_EN, limit=3 -> iter_count stops at 3, busy=0, and holding cmd=00 starts no further sweep.
